// File: rtl/secuenciador_pruebas_pkg.sv
// Shared types and constants for the register-write test sequencer.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
`timescale 1ns/1ps
package secuenciador_pkg;

    // Sequencer states, in the order the write sequence walks through them.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_DATO   = 3'd1,
        WR_SEND   = 3'd2,
        WAIT_DONE = 3'd3,
        WR_CLR    = 3'd4
    } estado_t;

    // Register-bus targets on the peripheral.
    localparam logic ADDR_DATO = 1'b0;
    localparam logic ADDR_CTRL = 1'b1;

    // Default control-register commands.
    localparam int unsigned CMD_SEND_DEF = 32'd1;
    localparam int unsigned CMD_CLR_DEF  = 32'd3;

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int ancho_contador(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/secuenciador_pruebas_if.sv
// Payload handshake plus peripheral register-write bus of the test sequencer.
// Latency: n/a (wires only).
// Backpressure: dato_ready_o gates dato_valid_i; the register bus has none.
//
// Modports:
//   master - the sequencer: takes the payload stream and done flag, drives
//            ready and the register write strobe/address/data.
//   slave  - the stimulus source plus peripheral side, the opposite view.
`timescale 1ns/1ps
interface secuenciador_pruebas_if #(
    parameter int DATA_W = 8,
    parameter int BUS_W  = 32
);
    logic [DATA_W-1:0] dato_i;
    logic              dato_valid_i;
    logic              dato_ready_o;
    logic              wr_o;
    logic              addr_o;
    logic [BUS_W-1:0]  entrada_o;
    logic              done_i;

    modport master (
        input  dato_i, dato_valid_i, done_i,
        output dato_ready_o, wr_o, addr_o, entrada_o
    );

    modport slave (
        output dato_i, dato_valid_i, done_i,
        input  dato_ready_o, wr_o, addr_o, entrada_o
    );
endinterface

// File: rtl/secuenciador_pruebas_contador_timeout.sv
// Loadable down-counter bounding the wait for the peripheral's done flag.
// Latency: expirado_o reflects the registered count (one cycle after clr/en).
// Backpressure: none; holds at zero once expired until reloaded.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset (count -> 0)
//   clr_i       - reload the count with valor_i (has priority over en_i)
//   en_i        - decrement by one while the count is non-zero
//   valor_i     - reload value
//   expirado_o  - count is zero
`timescale 1ns/1ps
module contador_timeout #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] valor_i,
    output logic         expirado_o
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr_i) begin
            cnt <= valor_i;
        end else if (en_i && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expirado_o = (cnt == '0);
endmodule

// File: rtl/secuenciador_pruebas.sv
// Accepts a payload word and issues data write, send command, wait for done, clear command.
// Latency: data write the cycle after accept; minimum 5 cycles from accept to next ready.
// Backpressure: dato_ready_o is high only in IDLE, so one payload is taken per sequence.
//
// Ports:
//   clk, rst  - clock (rising edge), asynchronous active-high reset
//   bus       - secuenciador_pruebas_if.master: payload handshake, done flag,
//               register write strobe / address / data
//   busy_o    - a sequence is in progress
//   error_o   - the last sequence ended on timeout (sticky until next accept)
//   cuenta_o  - completed (non-timed-out) sequences, wraps silently
//
// Build option: define SECUENCIADOR_TIMEOUT_EN to bound WAIT_DONE to TIMEOUT
// cycles and enable error_o; otherwise the wait is unbounded, error_o is 0
// and TIMEOUT only takes part in the parameter sanity check.
`timescale 1ns/1ps
module secuenciador_pruebas
    import secuenciador_pkg::*;
#(
    parameter int          DATA_W   = 8,
    parameter int          BUS_W    = 32,
    parameter int unsigned CMD_SEND = CMD_SEND_DEF,
    parameter int unsigned CMD_CLR  = CMD_CLR_DEF,
    parameter int          TIMEOUT  = 255,
    parameter int          COUNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    secuenciador_pruebas_if.master bus,
    output logic                  busy_o,
    output logic                  error_o,
    output logic [COUNT_W-1:0]    cuenta_o
);
    if ((DATA_W < 1) || (DATA_W > BUS_W) || (TIMEOUT < 1) || (COUNT_W < 1)) begin : g_param_invalido
        $error("secuenciador_pruebas: need 1 <= DATA_W <= BUS_W, TIMEOUT >= 1, COUNT_W >= 1");
    end

    estado_t             estado;
    estado_t             estado_sig;
    logic [DATA_W-1:0]   dato_q;
    logic                ready_q;
    logic                error_q;
    logic [COUNT_W-1:0]  cuenta_q;
    logic                acepta;
    logic                timeout_fin;

    // ready_q is only ever high in IDLE, so it alone qualifies the handshake.
    assign acepta = bus.dato_valid_i & ready_q;

`ifdef SECUENCIADOR_TIMEOUT_EN
    localparam int TO_W = ancho_contador(TIMEOUT);

    logic expirado;

    // Loaded with TIMEOUT-1 during the send write, so it reaches zero in the
    // TIMEOUT-th WAIT_DONE cycle; a done in that same cycle still wins.
    contador_timeout #(
        .W (TO_W)
    ) u_contador_timeout (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (estado == WR_SEND),
        .en_i       ((estado == WAIT_DONE) && !bus.done_i),
        .valor_i    (TO_W'(TIMEOUT - 1)),
        .expirado_o (expirado)
    );

    assign timeout_fin = (estado == WAIT_DONE) && expirado && !bus.done_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else if (acepta) begin
            error_q <= 1'b0;
        end else if (timeout_fin) begin
            error_q <= 1'b1;
        end
    end
`else
    assign timeout_fin = 1'b0;
    assign error_q     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
        end else begin
            estado <= estado_sig;
        end
    end

    always_comb begin
        estado_sig = estado;
        case (estado)
            IDLE:      if (acepta) estado_sig = WR_DATO;
            WR_DATO:   estado_sig = WR_SEND;
            WR_SEND:   estado_sig = WAIT_DONE;
            WAIT_DONE: if (bus.done_i || timeout_fin) estado_sig = WR_CLR;
            WR_CLR:    estado_sig = IDLE;
            default:   estado_sig = IDLE;
        endcase
    end

    // Ready is registered from the next state: low throughout reset, high in
    // the first cycle after release and in every IDLE cycle after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q  <= 1'b0;
            dato_q   <= '0;
            cuenta_q <= '0;
        end else begin
            ready_q <= (estado_sig == IDLE);
            if (acepta) begin
                dato_q <= bus.dato_i;
            end
            if ((estado == WR_CLR) && !error_q) begin
                cuenta_q <= cuenta_q + 1'b1;
            end
        end
    end

    // Register-bus decode from state alone; address and data are zero
    // whenever no write is strobed.
    always_comb begin
        bus.wr_o      = 1'b0;
        bus.addr_o    = 1'b0;
        bus.entrada_o = '0;
        case (estado)
            WR_DATO: begin
                bus.wr_o      = 1'b1;
                bus.addr_o    = ADDR_DATO;
                bus.entrada_o = BUS_W'(dato_q);
            end
            WR_SEND: begin
                bus.wr_o      = 1'b1;
                bus.addr_o    = ADDR_CTRL;
                bus.entrada_o = BUS_W'(CMD_SEND);
            end
            WR_CLR: begin
                bus.wr_o      = 1'b1;
                bus.addr_o    = ADDR_CTRL;
                bus.entrada_o = BUS_W'(CMD_CLR);
            end
            default: ;
        endcase
    end

    assign bus.dato_ready_o = ready_q;
    assign busy_o           = (estado != IDLE);
    assign error_o          = error_q;
    assign cuenta_o         = cuenta_q;
endmodule

// File: doc/secuenciador_pruebas.md
# secuenciador_pruebas

Parametrised write sequencer that replaces the static test mux in front of the UART/SPI register interface. It accepts a data word over a valid/ready handshake and issues a fixed three-write sequence on the peripheral register bus: data write, send command, clear command. Between the send and clear writes it waits for the peripheral's done flag, with an optional timeout. It sits between the bench or top-level stimulus source and the peripheral's register write port.

## Interface
- DATA_W, 8, width of payload word; must satisfy 1 ≤ DATA_W ≤ BUS_W
- BUS_W, 32, width of register write data
- CMD_SEND, 1, control-register value that starts a transfer
- CMD_CLR, 3, control-register value that clears status after a transfer
- TIMEOUT, 255, maximum cycles spent waiting for done (≥ 1; used only with TIMEOUT_EN)
- COUNT_W, 16, width of completed-transfer counter

- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- dato_i  in  DATA_W  payload word
- dato_valid_i  in  1  payload valid
- dato_ready_o  out  1  sequencer can accept payload
- wr_o  out  1  register write strobe, one cycle per write
- addr_o  out  1  write target: 0 = data register, 1 = control register
- entrada_o  out  BUS_W  register write data
- done_i  in  1  peripheral transfer complete (level or pulse)
- busy_o  out  1  sequence in progress
- error_o  out  1  last sequence ended on timeout
- cuenta_o  out  COUNT_W  number of completed sequences

## Operation
- Moore FSM. All outputs decode from registered state and registers only; there are no combinational input-to-output paths.
- **IDLE**: dato_ready_o=1, wr_o=0.
  - On dato_valid_i & dato_ready_o: latch dato_i, clear error_o, go to WR_DATO.
- **WR_DATO**: wr_o=1, addr_o=0, entrada_o = dato latched and zero-extended to BUS_W. Go to WR_SEND.
- **WR_SEND**: wr_o=1, addr_o=1, entrada_o = CMD_SEND zero-extended. Go to WAIT_DONE and clear the timeout counter.
- **WAIT_DONE**: wr_o=0.
  - done_i=1: go to WR_CLR.
  - Otherwise increment the timeout counter. When the counter reaches TIMEOUT-1 with done_i=0, set error_o and go to WR_CLR.
- **WR_CLR**: wr_o=1, addr_o=1, entrada_o = CMD_CLR zero-extended. Increment cuenta_o only if error_o=0. Go to IDLE.
- busy_o = state ≠ IDLE.
- entrada_o and addr_o are 0 whenever wr_o=0.
- done_i is ignored in every state except WAIT_DONE.
- cuenta_o wraps from 2^COUNT_W−1 to 0 silently.
- error_o is sticky until the next accepted payload.

## Timing
- Reset values: dato_ready_o=0 while rst is asserted and 1 in the first cycle after release. wr_o=0, addr_o=0, entrada_o=0, busy_o=0, error_o=0, cuenta_o=0. State is IDLE.
- Cycle numbering, with the payload accepted at the edge ending cycle 0:
  - cycle 1: data write.
  - cycle 2: send write.
  - cycle 3 onward: WAIT_DONE.
- If done_i is first sampled high in cycle k ≥ 3:
  - cycle k+1: clear write.
  - cycle k+2: IDLE with ready high.
  - Minimum sequence length is 5 cycles (accept to next ready).
- Timeout, done_i never high: WAIT_DONE lasts exactly TIMEOUT cycles, then the clear write occurs with error_o already high.
- done_i high in the same cycle the timeout would fire: done wins, no error.
- rst asserted mid-sequence: immediate return to IDLE with all outputs at reset values. No clear write is issued.
- Back-to-back payloads: valid held high is accepted on every IDLE cycle, i.e. once per sequence.

## Configuration
- Macro **SECUENCIADOR_TIMEOUT_EN**.
  - Defined: timeout counter and error path as above.
  - Undefined: the counter is not built, WAIT_DONE waits for done_i indefinitely, error_o is tied 0, and TIMEOUT is unused.

## Structure
- Package `secuenciador_pkg` contains:
  - the state enum (IDLE, WR_DATO, WR_SEND, WAIT_DONE, WR_CLR);
  - address constants ADDR_DATO=1'b0 and ADDR_CTRL=1'b1;
  - default command constants.
- One sub-module, `contador_timeout`: a loadable down-counter with clear/enable/expired, instantiated only under SECUENCIADOR_TIMEOUT_EN.

## Test plan
- **Reset, then single payload.** Reset, then dato_i=8'hA5 with valid for one cycle, done_i pulsed in cycle 5. Required writes: (addr0, 32'h000000A5) in cycle 1, (addr1, 32'h1) in cycle 2, (addr1, 32'h3) in cycle 6. Ready returns in cycle 7; cuenta_o=1.
- **Timeout.** TIMEOUT=4, done_i held 0. WAIT_DONE lasts 4 cycles, then the clear write with error_o=1 and cuenta_o unchanged. The next accept clears error_o.
- **Done and timeout coincide.** done_i=1 in the last timeout cycle. Required: error_o=0 and cuenta_o increments.
- **Mid-sequence reset.** Assert rst during WAIT_DONE. All outputs are 0 immediately; no CMD_CLR write follows; the next payload runs a full sequence.
- **Ignored done and back-to-back streaming.** Payloads 8'h00 and 8'hFF with valid held high; done_i high during WR_DATO is ignored. Required: two complete sequences and cuenta_o=2. With COUNT_W=2, after 5 sequences cuenta_o=1 (wrap).
- **Macro undefined.** done_i withheld for 1000 cycles: busy_o stays 1 and error_o stays 0. Pulse done_i: clear write follows in the next cycle.
